// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the two-port DRAM user-port arbiter.
package dram_arb_pkg;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_INST = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// Request-side and DRAM-side bundle of the arbiter; slave is the arbiter's view.
interface dram_arbiter_if #(
  parameter int ADDR_W = dram_arb_pkg::ADDR_W,
  parameter int DATA_W = dram_arb_pkg::DATA_W
);
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_din0;
  logic [DATA_W-1:0] req_din1;
  logic [1:0]        req_rw;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_dout;

  logic [ADDR_W-1:0] addr_dram;
  logic [DATA_W-1:0] din_dram;
  logic              rw_dram;
  logic              valid_dram;
  logic [DATA_W-1:0] dout_dram;
  logic              ready_dram;

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_din0, req_din1, req_rw,
    input  dout_dram, ready_dram,
    output req_ready, req_dout,
    output addr_dram, din_dram, rw_dram, valid_dram
  );

  modport master (
    output req_valid, req_addr0, req_addr1, req_din0, req_din1, req_rw,
    output dout_dram, ready_dram,
    input  req_ready, req_dout,
    input  addr_dram, din_dram, rw_dram, valid_dram
  );
endinterface

// File: rtl/dram_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  assign gnt_valid = |req;
  assign gnt_idx   = (req == 2'b11) ? ~last : req[1];
endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM user port between the data path (port 0) and instruction/loader path (port 1).
//   state | meaning
//   IDLE  | waiting for a request, grant decided here only
//   BUSY  | request held on the DRAM port until ready_dram
//   DONE  | one-cycle req_ready pulse to the granted port, no grant
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W = dram_arb_pkg::ADDR_W,
  parameter int DATA_W = dram_arb_pkg::DATA_W
) (
  input  logic           clk,
  input  logic           rstn,
  dram_arbiter_if.slave  bus
);

  arb_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              rw_q;
  logic              gnt;
  logic              last;
  logic [1:0]        ready_q;
  logic [DATA_W-1:0] dout_q;
  logic              pick_valid;
  logic              pick_idx;

  rr_pick2 u_pick (
    .req       (bus.req_valid),
    .last      (last),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      rw_q    <= 1'b0;
      gnt     <= PORT_DATA;
      last    <= PORT_INST;
      ready_q <= 2'b00;
      dout_q  <= '0;
    end else begin
      ready_q <= 2'b00;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            addr_q <= pick_idx ? bus.req_addr1 : bus.req_addr0;
            din_q  <= pick_idx ? bus.req_din1  : bus.req_din0;
            rw_q   <= bus.req_rw[pick_idx];
            gnt    <= pick_idx;
            last   <= pick_idx;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (bus.ready_dram) begin
            // write completions leave the last read data in place
            if (!rw_q) dout_q <= bus.dout_dram;
            ready_q <= gnt ? 2'b10 : 2'b01;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr_dram  = addr_q;
  assign bus.din_dram   = din_q;
  assign bus.rw_dram    = rw_q;
  // drop valid in the completion cycle so the controller never sees a second request
  assign bus.valid_dram = (state == BUSY) && !bus.ready_dram;
  assign bus.req_ready  = ready_q;
  assign bus.req_dout   = dout_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus a randomized request stream.
module tb_dram_arbiter;
  import dram_arb_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model: pending op per port, last served port, visible read data, memory image
  bit            pend   [2];
  bit            op_rw  [2];
  logic [AW-1:0] op_addr[2];
  logic [DW-1:0] op_din [2];
  bit            last_m;
  bit            in_done;
  logic [DW-1:0] dout_m;
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] dram_mem[int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] dram_rd(input int a);
    return dram_mem.exists(a) ? dram_mem[a] : '0;
  endfunction

  task automatic post(input int p, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p]    = 1'b1;
    op_rw[p]   = rw;
    op_addr[p] = a;
    op_din[p]  = d;
    bus.req_rw[p]    = rw;
    bus.req_valid[p] = 1'b1;
    if (p == 0) begin
      bus.req_addr0 = a;
      bus.req_din0  = d;
    end else begin
      bus.req_addr1 = a;
      bus.req_din1  = d;
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid  = 2'b00;
    bus.req_rw     = 2'b00;
    bus.req_addr0  = '0;
    bus.req_addr1  = '0;
    bus.req_din0   = '0;
    bus.req_din1   = '0;
    bus.ready_dram = 1'b0;
    bus.dout_dram  = '0;
  endtask

  task automatic reset_model();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last_m  = 1'b1;
    dout_m  = '0;
    in_done = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    step();
    step();
    chk("rst_valid_dram", bus.valid_dram, 1'b0);
    chk("rst_req_ready",  bus.req_ready,  2'b00);
    chk("rst_addr_dram",  bus.addr_dram,  '0);
    chk("rst_din_dram",   bus.din_dram,   '0);
    chk("rst_rw_dram",    bus.rw_dram,    1'b0);
    chk("rst_req_dout",   bus.req_dout,   '0);
    rstn = 1'b1;
    reset_model();
  endtask

  // Serve the request the model says wins next; returns with the DUT in its DONE cycle
  // (or in IDLE when the requester holds valid through DONE).
  task automatic serve_one(input int lat, input bit hold_extra);
    int            exp_p;
    int            n;
    logic [DW-1:0] rdat;
    if (!pend[0] && !pend[1]) begin
      chk("serve_without_request", 1, 0);
      return;
    end
    exp_p = (pend[0] && pend[1]) ? (1 - int'(last_m)) : (pend[1] ? 1 : 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.valid_dram && n < 6);
    chk("grant_latency", n, in_done ? 2 : 1);
    chk("dram_addr", bus.addr_dram, op_addr[exp_p]);
    chk("dram_rw",   bus.rw_dram,   op_rw[exp_p]);
    if (op_rw[exp_p]) chk("dram_din", bus.din_dram, op_din[exp_p]);
    repeat (lat) begin
      step();
      chk("valid_hold",     bus.valid_dram, 1'b1);
      chk("no_early_ready", bus.req_ready,  2'b00);
    end
    rdat = dram_rd(int'(bus.addr_dram));
    if (bus.rw_dram) dram_mem[int'(bus.addr_dram)] = bus.din_dram;
    bus.dout_dram  = op_rw[exp_p] ? DW'($urandom) : rdat;
    bus.ready_dram = 1'b1;
    #1;
    chk("valid_gated", bus.valid_dram, 1'b0);
    step();
    bus.ready_dram = 1'b0;
    bus.dout_dram  = DW'($urandom);
    if (op_rw[exp_p]) ref_mem[int'(op_addr[exp_p])] = op_din[exp_p];
    else              dout_m = ref_rd(int'(op_addr[exp_p]));
    chk("req_ready",      bus.req_ready,  2'b01 << exp_p);
    chk("req_dout",       bus.req_dout,   dout_m);
    chk("done_valid_low", bus.valid_dram, 1'b0);
    last_m = exp_p[0];
    pend[exp_p] = 1'b0;
    if (!hold_extra) begin
      bus.req_valid[exp_p] = 1'b0;
      in_done = 1'b1;
    end else begin
      step();
      chk("idle_ready_low", bus.req_ready,  2'b00);
      chk("idle_valid_low", bus.valid_dram, 1'b0);
      bus.req_valid[exp_p] = 1'b0;
      in_done = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // port 0 write then read back
    post(0, 1'b1, AW'(0), 32'h0f0f0f0f);
    serve_one(2, 1'b0);
    post(0, 1'b0, AW'(0), '0);
    serve_one(1, 1'b0);
    chk("p0_read_data", bus.req_dout, 32'h0f0f0f0f);

    // port 1 alone
    post(1, 1'b1, AW'(4), 32'h1e1e1e1e);
    serve_one(0, 1'b0);
    post(1, 1'b0, AW'(4), '0);
    serve_one(3, 1'b0);
    chk("p1_read_data", bus.req_dout, 32'h1e1e1e1e);

    // simultaneous pairs after reset: port 0 first, alternating thereafter
    do_reset();
    post(0, 1'b0, AW'(0), '0);
    post(1, 1'b0, AW'(4), '0);
    serve_one(1, 1'b0);
    chk("pair1_first_p0", bus.req_ready, 2'b01);
    serve_one(0, 1'b0);
    chk("pair1_second_p1", bus.req_ready, 2'b10);
    post(0, 1'b0, AW'(4), '0);
    post(1, 1'b0, AW'(0), '0);
    serve_one(2, 1'b0);
    chk("pair2_first_p0", bus.req_ready, 2'b01);
    serve_one(1, 1'b0);
    chk("pair2_second_p1", bus.req_ready, 2'b10);

    // stray ready_dram in IDLE
    step();
    in_done = 1'b0;
    bus.ready_dram = 1'b1;
    step();
    bus.ready_dram = 1'b0;
    chk("stray_no_ready", bus.req_ready, 2'b00);
    chk("stray_no_valid", bus.valid_dram, 1'b0);
    step();
    chk("stray_no_ready_late", bus.req_ready, 2'b00);
    post(0, 1'b0, AW'(4), '0);
    serve_one(1, 1'b0);

    // requester holds valid through DONE: no second transaction
    post(1, 1'b1, AW'(8), 32'hcafe_0001);
    serve_one(1, 1'b1);
    step();
    chk("done_gap_no_dup", bus.valid_dram, 1'b0);
    step();
    chk("done_gap_no_dup2", bus.valid_dram, 1'b0);
    chk("done_gap_no_ready", bus.req_ready, 2'b00);

    // reset while BUSY
    post(0, 1'b1, AW'(12), 32'hdead_beef);
    step();
    chk("mid_busy_valid", bus.valid_dram, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid",  bus.valid_dram, 1'b0);
    chk("mid_rst_ready",  bus.req_ready,  2'b00);
    chk("mid_rst_dout",   bus.req_dout,   '0);
    clear_inputs();
    step();
    rstn = 1'b1;
    reset_model();
    bus.ready_dram = 1'b1;
    step();
    bus.ready_dram = 1'b0;
    chk("late_completion_dropped", bus.req_ready, 2'b00);
    step();
    post(1, 1'b0, AW'(4), '0);
    serve_one(1, 1'b0);
    chk("post_rst_p1_data", bus.req_dout, 32'h1e1e1e1e);

    // randomized request stream
    for (int it = 0; it < 80; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0)
          post(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
      end
      if (!pend[0] && !pend[1])
        post(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 15)), DW'($urandom));
      serve_one(int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
    end

    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
